rd_channel_arbiter: RTL and testbench



---
 rtl/rd_arb_pkg.sv | 16 +
 rtl/rd_arb_buf2.sv | 52 +++++
 rtl/rd_channel_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rd_channel_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_arb_pkg.sv
// Shared definitions for the read-channel arbiter: sequencer states and default widths.
package rd_arb_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int TAG_WIDTH_DEF   = 4;
    localparam int LEN_WIDTH_DEF   = 8;
    localparam int CFG_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CFG      = 2'd1,
        WAIT_RDY = 2'd2,
        XFER     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rd_arb_buf2.sv
// Two-entry registered FIFO returning words to the core; push and pop may coincide at any occupancy.
module rd_arb_buf2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head is forced to zero when empty so a flushed buffer shows no stale word.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/rd_channel_arbiter.sv
// Read command sequencer: configures one of two FIFO read channels, pops a burst of words
// and returns them to the core through a 2-entry buffered stream.
module rd_channel_arbiter
    import rd_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int TAG_WIDTH   = TAG_WIDTH_DEF,
    parameter int LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int CFG_TIMEOUT = CFG_TIMEOUT_DEF
) (
    input  logic                  clk_chip,
    input  logic                  reset_chip,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_ch,
    input  logic [TAG_WIDTH-1:0]  cmd_tag,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  config_paulse_ch0,
    output logic                  config_paulse_ch1,
    output logic [TAG_WIDTH-1:0]  config_data_ch0,
    output logic [TAG_WIDTH-1:0]  config_data_ch1,
    input  logic                  config_ready_ch0,
    input  logic                  config_ready_ch1,
    output logic                  rd_req_ch0,
    output logic                  rd_req_ch1,
    input  logic                  rd_valid_ch0,
    input  logic                  rd_valid_ch1,
    input  logic [DATA_WIDTH-1:0] rd_data_ch0,
    input  logic [DATA_WIDTH-1:0] rd_data_ch1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_last,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_spurious,
    output arb_state_t            state_dbg
);

    localparam int TIMER_WIDTH = $clog2(CFG_TIMEOUT + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(CFG_TIMEOUT - 1);

    arb_state_t              state, state_nxt;
    logic                    sel_ch;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [LEN_WIDTH:0]      req_left, pop_left, len_ext;
    logic [1:0]              outstanding, buf_count;
    logic [TIMER_WIDTH-1:0]  timer;
    logic                    sel_ready, sel_valid;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    buf_empty, buf_full;
    logic                    push, pop, room, issue, cfg_strobe, spurious;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // valid never waits on ready, and once raised, valid and its payload hold until that cycle.
    assign len_ext   = {(cmd_len == '0), cmd_len};
    assign sel_ready = sel_ch ? config_ready_ch1 : config_ready_ch0;
    assign sel_valid = sel_ch ? rd_valid_ch1 : rd_valid_ch0;
    assign sel_data  = sel_ch ? rd_data_ch1 : rd_data_ch0;

    assign out_valid = ~buf_empty;
    assign pop       = out_valid & out_ready;
    assign push      = sel_valid & (outstanding != 2'd0);
    assign spurious  = (rd_valid_ch0 & (sel_ch | (outstanding == 2'd0))) |
                       (rd_valid_ch1 & (~sel_ch | (outstanding == 2'd0)));

    // In-flight words plus buffered words never exceed two; a same-cycle pop frees a slot.
    assign room  = pop | (~buf_full & (({1'b0, outstanding} + {1'b0, buf_count}) < 3'd2));
    assign issue = (state == XFER) & (req_left != '0) & room;

    assign out_last = (pop_left == (LEN_WIDTH + 1)'(1)) & out_valid;
    assign out_tag  = tag_q;
    assign state_dbg = state;

    assign config_paulse_ch0 = cfg_strobe & ~sel_ch;
    assign config_paulse_ch1 = cfg_strobe & sel_ch;
    assign config_data_ch0   = ((state != IDLE) & ~sel_ch) ? tag_q : '0;
    assign config_data_ch1   = ((state != IDLE) & sel_ch) ? tag_q : '0;
    assign rd_req_ch0        = issue & ~sel_ch;
    assign rd_req_ch1        = issue & sel_ch;

    rd_arb_buf2 #(.WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk_chip),
        .reset     (reset_chip),
        .push      (push),
        .push_data (sel_data),
        .pop       (pop),
        .head_data (out_data),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        cfg_strobe = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~reset_chip;
                if (cmd_valid & ~reset_chip) begin
                    state_nxt = CFG;
                end
            end
            CFG: begin
                cfg_strobe = 1'b1;
                state_nxt  = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (sel_ready) begin
                    state_nxt = XFER;
                end else if (timer == TIMER_LAST) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (pop & out_last) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_chip) begin
        if (reset_chip) begin
            state        <= IDLE;
            sel_ch       <= 1'b0;
            tag_q        <= '0;
            req_left     <= '0;
            pop_left     <= '0;
            outstanding  <= 2'd0;
            timer        <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) & cmd_valid) begin
                sel_ch   <= cmd_ch;
                tag_q    <= cmd_tag;
                req_left <= len_ext;
                pop_left <= len_ext;
            end
            if (state == CFG) begin
                timer <= '0;
            end else if (state == WAIT_RDY) begin
                timer <= timer + 1'b1;
            end
            if ((state == WAIT_RDY) & ~sel_ready & (timer == TIMER_LAST)) begin
                err_timeout <= 1'b1;
            end
            if (issue) begin
                req_left <= req_left - 1'b1;
            end
            if (pop) begin
                pop_left <= pop_left - 1'b1;
            end
            outstanding <= outstanding + {1'b0, issue} - {1'b0, push};
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rd_channel_arbiter.sv
// Directed bench for rd_channel_arbiter: channel responder models, output scoreboard, summary.
module tb_rd_channel_arbiter;
  import rd_arb_pkg::*;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int LW = 8;
  localparam int TO = 255;

  // ---------------- clock / reset ----------------
  logic clk_chip = 1'b0;
  logic reset_chip = 1'b1;
  always #5 clk_chip = ~clk_chip;

  int cyc = 0;
  always @(posedge clk_chip) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          cmd_valid = 1'b0, cmd_ready, cmd_ch = 1'b0;
  logic [TW-1:0] cmd_tag = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          config_paulse_ch0, config_paulse_ch1;
  logic [TW-1:0] config_data_ch0, config_data_ch1;
  logic          config_ready_ch0 = 1'b0, config_ready_ch1 = 1'b0;
  logic          rd_req_ch0, rd_req_ch1, rd_valid_ch0, rd_valid_ch1;
  logic [DW-1:0] rd_data_ch0, rd_data_ch1;
  logic          out_valid, out_ready = 1'b0, out_last, done, err_timeout, err_spurious;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  arb_state_t    state_dbg;

  logic [1:0]    resp_v = 2'b00;
  logic [DW-1:0] resp_d0 = '0, resp_d1 = '0;
  logic          inj_v = 1'b0;

  assign rd_valid_ch0 = resp_v[0] | inj_v;
  assign rd_valid_ch1 = resp_v[1];
  assign rd_data_ch0  = resp_d0;
  assign rd_data_ch1  = resp_d1;

  rd_channel_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .LEN_WIDTH(LW), .CFG_TIMEOUT(TO)) dut (
    .clk_chip(clk_chip), .reset_chip(reset_chip),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_tag(cmd_tag), .cmd_len(cmd_len),
    .config_paulse_ch0(config_paulse_ch0), .config_paulse_ch1(config_paulse_ch1),
    .config_data_ch0(config_data_ch0), .config_data_ch1(config_data_ch1),
    .config_ready_ch0(config_ready_ch0), .config_ready_ch1(config_ready_ch1),
    .rd_req_ch0(rd_req_ch0), .rd_req_ch1(rd_req_ch1),
    .rd_valid_ch0(rd_valid_ch0), .rd_valid_ch1(rd_valid_ch1),
    .rd_data_ch0(rd_data_ch0), .rd_data_ch1(rd_data_ch1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .done(done), .err_timeout(err_timeout), .err_spurious(err_spurious),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int due_q0[$], due_q1[$];
  int delay_ch[2] = '{1, 1};
  logic [DW-1:0] data_next[2] = '{32'h0, 32'h0};
  int n_req[2] = '{0, 0};
  int n_paulse[2] = '{0, 0};
  int bench_outst[2] = '{0, 0};
  int max_outst = 0;
  int n_done = 0;
  int n_pop = 0;
  int n_extra = 0;
  int unsel_bad = 0;
  bit active = 1'b0;
  bit cur_ch = 1'b0;
  logic [TW-1:0] cur_tag = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- channel responders and output monitor ----------------
  always begin
    @(negedge clk_chip);
    resp_v = 2'b00;
    resp_d0 = '0;
    resp_d1 = '0;
    if (due_q0.size() > 0 && due_q0[0] <= cyc) begin
      void'(due_q0.pop_front());
      resp_v[0] = 1'b1;
      resp_d0 = data_next[0];
      data_next[0] = data_next[0] + 1;
      bench_outst[0]--;
    end
    if (due_q1.size() > 0 && due_q1[0] <= cyc) begin
      void'(due_q1.pop_front());
      resp_v[1] = 1'b1;
      resp_d1 = data_next[1];
      data_next[1] = data_next[1] + 1;
      bench_outst[1]--;
    end
    #1;
    if (!reset_chip) begin
      if (rd_req_ch0) begin
        n_req[0]++;
        due_q0.push_back(cyc + delay_ch[0]);
        bench_outst[0]++;
      end
      if (rd_req_ch1) begin
        n_req[1]++;
        due_q1.push_back(cyc + delay_ch[1]);
        bench_outst[1]++;
      end
      if (bench_outst[0] > max_outst) max_outst = bench_outst[0];
      if (bench_outst[1] > max_outst) max_outst = bench_outst[1];
      if (config_paulse_ch0) n_paulse[0]++;
      if (config_paulse_ch1) n_paulse[1]++;
      if (!active) begin
        if (rd_req_ch0 || rd_req_ch1 || config_paulse_ch0 || config_paulse_ch1 ||
            config_data_ch0 != '0 || config_data_ch1 != '0) unsel_bad++;
      end else if (cur_ch == 1'b0) begin
        if (rd_req_ch1 || config_paulse_ch1 || config_data_ch1 != '0) unsel_bad++;
      end else begin
        if (rd_req_ch0 || config_paulse_ch0 || config_data_ch0 != '0) unsel_bad++;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_extra++;
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check_eq("out_data", out_data, e);
          check_eq("out_last", out_last, exp_q.size() == 0);
          check_eq("out_tag", out_tag, cur_tag);
        end
      end
      if (done) n_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_chip);
  endtask

  task automatic look();
    #2;
  endtask

  // Offers one command; returns in the first WAIT_RDY window with the accept cycle.
  task automatic issue_cmd(input bit ch, input logic [TW-1:0] tag, input logic [LW-1:0] len,
                           input int delay, input logic [DW-1:0] base, output int acc_cyc);
    int n;
    n = (len == 0) ? 256 : int'(len);
    step();
    cmd_valid = 1'b1;
    cmd_ch = ch;
    cmd_tag = tag;
    cmd_len = len;
    cur_ch = ch;
    cur_tag = tag;
    active = 1'b1;
    delay_ch[ch] = delay;
    data_next[ch] = base;
    for (int i = 0; i < n; i++) exp_q.push_back(base + DW'(i));
    look();
    check_eq("accept_cmd_ready", cmd_ready, 1);
    acc_cyc = cyc;
    step();
    cmd_valid = 1'b0;
    look();
    check_eq("cfg_paulse", ch ? config_paulse_ch1 : config_paulse_ch0, 1);
    check_eq("cfg_data", ch ? config_data_ch1 : config_data_ch0, tag);
    step();
  endtask

  // Pulses config_ready in the current window and checks the first request follows one cycle later.
  task automatic give_ready(input bit ch, output int rdy_cyc);
    if (ch) config_ready_ch1 = 1'b1; else config_ready_ch0 = 1'b1;
    look();
    check_eq("req_before_ready", ch ? rd_req_ch1 : rd_req_ch0, 0);
    rdy_cyc = cyc;
    step();
    config_ready_ch0 = 1'b0;
    config_ready_ch1 = 1'b0;
    look();
    check_eq("first_req_latency", ch ? rd_req_ch1 : rd_req_ch0, 1);
  endtask

  task automatic wait_done(input int bound, output int dcyc);
    bit got;
    got = 1'b0;
    dcyc = 0;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      look();
      if (done) begin
        got = 1'b1;
        dcyc = cyc;
      end
    end
    check_eq("done_seen", got, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc, rdy, dc, req0, req1, pops, dn;

    step();
    look();
    check_eq("rst_cmd_ready_low", cmd_ready, 0);
    step();
    reset_chip = 1'b0;
    look();
    check_eq("post_rst_cmd_ready", cmd_ready, 1);
    check_eq("post_rst_out_valid", out_valid, 0);
    check_eq("post_rst_done", done, 0);
    check_eq("post_rst_errs", {err_timeout, err_spurious}, 0);
    check_eq("post_rst_chan", {rd_req_ch0, rd_req_ch1, config_paulse_ch0, config_paulse_ch1,
                               config_data_ch0, config_data_ch1}, 0);

    // Burst of 4 on ch0 at full rate.
    out_ready = 1'b1;
    issue_cmd(1'b0, 4'h3, 8'd4, 1, 32'hA0, acc);
    give_ready(1'b0, rdy);
    wait_done(40, dc);
    active = 1'b0;
    check_eq("t1_done_latency", dc - rdy, 6);
    check_eq("t1_req_ch0", n_req[0], 4);
    check_eq("t1_req_ch1", n_req[1], 0);
    check_eq("t1_paulse", {n_paulse[1][7:0], n_paulse[0][7:0]}, 16'h0001);
    check_eq("t1_words_left", exp_q.size(), 0);
    check_eq("t1_done_count", n_done, 1);

    // 256-word burst on ch1 with delayed returns.
    req1 = n_req[1];
    issue_cmd(1'b1, 4'h5, 8'd0, 3, 32'h1000, acc);
    give_ready(1'b1, rdy);
    wait_done(2000, dc);
    active = 1'b0;
    check_eq("t2_req_ch1", n_req[1] - req1, 256);
    check_eq("t2_outst_le2", max_outst <= 2, 1);
    check_eq("t2_words_left", exp_q.size(), 0);
    check_eq("t2_done_count", n_done, 2);

    // Backpressure after the first word.
    req0 = n_req[0];
    pops = n_pop;
    issue_cmd(1'b0, 4'h9, 8'd6, 1, 32'hC0, acc);
    give_ready(1'b0, rdy);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      step();
      look();
    end
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    look();
    check_eq("t3_held_valid", out_valid, 1);
    check_eq("t3_held_data", out_data, 32'hC1);
    check_eq("t3_req_stalled", n_req[0] - req0, 3);
    check_eq("t3_one_pop", n_pop - pops, 1);
    for (int i = 0; i < 3; i++) step();
    look();
    check_eq("t3_data_stable", out_data, 32'hC1);
    step();
    out_ready = 1'b1;
    wait_done(40, dc);
    active = 1'b0;
    check_eq("t3_req_total", n_req[0] - req0, 6);
    check_eq("t3_words_left", exp_q.size(), 0);

    // Config timeout.
    req0 = n_req[0];
    pops = n_pop;
    issue_cmd(1'b0, 4'h2, 8'd3, 1, 32'hD0, acc);
    wait_done(400, dc);
    active = 1'b0;
    check_eq("t4_timeout_cycles", dc - acc, 256);
    check_eq("t4_err_not_yet", err_timeout, 0);
    step();
    look();
    check_eq("t4_err_timeout", err_timeout, 1);
    check_eq("t4_cmd_ready", cmd_ready, 1);
    check_eq("t4_no_req", n_req[0] - req0, 0);
    check_eq("t4_no_pop", n_pop - pops, 0);
    exp_q.delete();

    // Spurious return while idle.
    check_eq("t5_spur_clear", err_spurious, 0);
    step();
    inj_v = 1'b1;
    look();
    step();
    inj_v = 1'b0;
    look();
    check_eq("t5_err_spurious", err_spurious, 1);
    check_eq("t5_no_out_valid", out_valid, 0);

    // Reset during a transfer with the buffer full.
    out_ready = 1'b0;
    issue_cmd(1'b1, 4'h6, 8'd8, 1, 32'h200, acc);
    give_ready(1'b1, rdy);
    for (int i = 0; i < 8; i++) step();
    look();
    check_eq("t6_buffered", out_valid, 1);
    dn = n_done;
    step();
    reset_chip = 1'b1;
    exp_q.delete();
    due_q0.delete();
    due_q1.delete();
    active = 1'b0;
    look();
    step();
    reset_chip = 1'b0;
    bench_outst[0] = 0;
    bench_outst[1] = 0;
    look();
    check_eq("t6_out_valid", out_valid, 0);
    check_eq("t6_chan_zero", {rd_req_ch1, config_paulse_ch1, config_data_ch1}, 0);
    check_eq("t6_errs_cleared", {err_timeout, err_spurious}, 0);
    check_eq("t6_cmd_ready", cmd_ready, 1);
    check_eq("t6_out_tag", out_tag, 0);
    check_eq("t6_no_done", n_done - dn, 0);

    out_ready = 1'b1;
    issue_cmd(1'b0, 4'h7, 8'd2, 2, 32'h300, acc);
    give_ready(1'b0, rdy);
    wait_done(40, dc);
    active = 1'b0;
    check_eq("t6_new_done", n_done - dn, 1);
    check_eq("t6_words_left", exp_q.size(), 0);

    step();
    look();
    check_eq("unselected_quiet", unsel_bad, 0);
    check_eq("extra_pops", n_extra, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
